// File: rtl/nn_layer_engine_if.sv
// Host, descriptor and memory bus of the layer engine.
// The engine uses the slave modport. The host and memory side uses the master modport.
interface nn_layer_engine_if #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int MAX_LAYERS = 4,
    parameter int LW         = $clog2(MAX_LAYERS + 1),
    parameter int IDX_W      = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1
);
    // run control
    logic                      start;
    logic [LW-1:0]             num_layers;
    logic [ADDR_W-1:0]         in_base;
    logic                      busy;
    logic                      done;
    logic                      err;
    logic [ADDR_W-1:0]         out_base;
    // descriptor programming
    logic                      cfg_we;
    logic [IDX_W-1:0]          cfg_addr;
    logic [ADDR_W-1:0]         cfg_n_in;
    logic [ADDR_W-1:0]         cfg_n_out;
    logic                      cfg_relu;
    // weight and neuron memories
    logic [ADDR_W-1:0]         w_addr;
    logic signed [DATA_W-1:0]  w_data;
    logic [ADDR_W-1:0]         n_rd_addr;
    logic signed [DATA_W-1:0]  n_rd_data;
    logic                      n_wr_en;
    logic [ADDR_W-1:0]         n_wr_addr;
    logic signed [DATA_W-1:0]  n_wr_data;

    modport slave (
        input  start, num_layers, in_base,
        input  cfg_we, cfg_addr, cfg_n_in, cfg_n_out, cfg_relu,
        input  w_data, n_rd_data,
        output busy, done, err, out_base,
        output w_addr, n_rd_addr, n_wr_en, n_wr_addr, n_wr_data
    );

    modport master (
        output start, num_layers, in_base,
        output cfg_we, cfg_addr, cfg_n_in, cfg_n_out, cfg_relu,
        output w_data, n_rd_data,
        input  busy, done, err, out_base,
        input  w_addr, n_rd_addr, n_wr_en, n_wr_addr, n_wr_data
    );
endinterface

// File: rtl/nn_layer_engine.sv
// Multi-layer fully-connected inference engine.
// It streams weights linearly from weight memory. Each layer reads its input vector
// from neuron memory and writes its outputs directly after that vector. The written
// outputs then become the input vector of the next layer.
module nn_layer_engine #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int ACC_W      = 24,
    parameter int FRAC_BITS  = 4,
    parameter int MAX_LAYERS = 4,
    parameter int LW         = $clog2(MAX_LAYERS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    nn_layer_engine_if.slave   bus
);
    localparam int IDX_W = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1;
    localparam int PROD_W = 2 * DATA_W;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DATA_W - 1)));

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_MAC, S_DRAIN, S_WRITE, S_FINISH
    } state_t;

    state_t state_reg, state_next;

    // run-level registers
    logic [LW-1:0]      layers_reg;
    logic [LW-1:0]      layer_reg;
    logic [ADDR_W-1:0]  w_ptr_reg;
    logic [ADDR_W-1:0]  rd_base_reg;
    logic [ADDR_W-1:0]  wr_base_reg;
    logic [ADDR_W-1:0]  out_base_reg;
    logic               err_reg;
    // per-layer registers, loaded in SETUP
    logic [ADDR_W-1:0]  n_in_reg;
    logic [ADDR_W-1:0]  n_out_reg;
    logic               relu_reg;
    // loop counters: i indexes inputs, j indexes output neurons
    logic [ADDR_W-1:0]  i_reg;
    logic [ADDR_W-1:0]  j_reg;
    // accumulator and the flag marking that the memories return a product this cycle
    logic signed [ACC_W-1:0] acc_reg;
    logic                    prod_valid_reg;

    // descriptor table, one register slice per entry
    logic [ADDR_W-1:0]  desc_n_in  [MAX_LAYERS];
    logic [ADDR_W-1:0]  desc_n_out [MAX_LAYERS];
    logic               desc_relu  [MAX_LAYERS];

    logic               busy_c;
    logic               cfg_wr;
    logic [IDX_W-1:0]   layer_idx;
    logic [ADDR_W-1:0]  cur_n_in;
    logic [ADDR_W-1:0]  cur_n_out;
    logic               cur_relu;
    logic               desc_bad;
    logic               last_input;
    logic               last_neuron;
    logic               last_layer;

    // Descriptors may only change while the engine is not running a layer sequence.
    assign cfg_wr = bus.cfg_we && !busy_c;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LAYERS; gi++) begin : g_desc
            logic [ADDR_W-1:0] n_in_reg;
            logic [ADDR_W-1:0] n_out_reg;
            logic              relu_reg;

            // descriptor entry gi: written when addressed and the engine is idle
            always_ff @(posedge clk) begin
                if (reset) begin
                    n_in_reg  <= '0;
                    n_out_reg <= '0;
                    relu_reg  <= 1'b0;
                end else if (cfg_wr && (bus.cfg_addr == IDX_W'(gi))) begin
                    n_in_reg  <= bus.cfg_n_in;
                    n_out_reg <= bus.cfg_n_out;
                    relu_reg  <= bus.cfg_relu;
                end
            end

            assign desc_n_in[gi]  = n_in_reg;
            assign desc_n_out[gi] = n_out_reg;
            assign desc_relu[gi]  = relu_reg;
        end
    endgenerate

    assign layer_idx   = layer_reg[IDX_W-1:0];
    assign cur_n_in    = desc_n_in[layer_idx];
    assign cur_n_out   = desc_n_out[layer_idx];
    assign cur_relu    = desc_relu[layer_idx];
    assign desc_bad    = (cur_n_in == '0) || (cur_n_out == '0);
    assign last_input  = (i_reg == n_in_reg - ADDR_W'(1));
    assign last_neuron = (j_reg == n_out_reg - ADDR_W'(1));
    assign last_layer  = (layer_reg == layers_reg - LW'(1));

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = (bus.num_layers == '0) ? S_FINISH : S_SETUP;
                end
            end
            S_SETUP:  state_next = desc_bad ? S_FINISH : S_MAC;
            S_MAC:    state_next = last_input ? S_DRAIN : S_MAC;
            S_DRAIN:  state_next = S_WRITE;
            S_WRITE: begin
                if (!last_neuron) begin
                    state_next = S_MAC;
                end else if (last_layer) begin
                    state_next = S_FINISH;
                end else begin
                    state_next = S_SETUP;
                end
            end
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // sequencing registers: pointers, bases, counters and status
    always_ff @(posedge clk) begin
        if (reset) begin
            layers_reg   <= '0;
            layer_reg    <= '0;
            w_ptr_reg    <= '0;
            rd_base_reg  <= '0;
            wr_base_reg  <= '0;
            out_base_reg <= '0;
            err_reg      <= 1'b0;
            n_in_reg     <= '0;
            n_out_reg    <= '0;
            relu_reg     <= 1'b0;
            i_reg        <= '0;
            j_reg        <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        layers_reg  <= bus.num_layers;
                        layer_reg   <= '0;
                        w_ptr_reg   <= '0;
                        rd_base_reg <= bus.in_base;
                        err_reg     <= 1'b0;
                        if (bus.num_layers == '0) begin
                            out_base_reg <= bus.in_base;
                        end
                    end
                end
                S_SETUP: begin
                    n_in_reg  <= cur_n_in;
                    n_out_reg <= cur_n_out;
                    relu_reg  <= cur_relu;
                    i_reg     <= '0;
                    j_reg     <= '0;
                    if (desc_bad) begin
                        err_reg <= 1'b1;
                    end else begin
                        wr_base_reg <= rd_base_reg + cur_n_in;
                    end
                end
                S_MAC: begin
                    w_ptr_reg <= w_ptr_reg + ADDR_W'(1);
                    i_reg     <= i_reg + ADDR_W'(1);
                end
                S_WRITE: begin
                    i_reg <= '0;
                    j_reg <= j_reg + ADDR_W'(1);
                    if (last_neuron) begin
                        if (last_layer) begin
                            out_base_reg <= wr_base_reg;
                        end else begin
                            rd_base_reg <= wr_base_reg;
                            layer_reg   <= layer_reg + LW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    assign prod     = bus.w_data * bus.n_rd_data;
    assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

    // accumulate the product that returns one cycle after each MAC address is issued
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg        <= '0;
            prod_valid_reg <= 1'b0;
        end else begin
            prod_valid_reg <= (state_reg == S_MAC);
            if ((state_reg == S_SETUP) || (state_reg == S_WRITE)) begin
                acc_reg <= '0;
            end else if (prod_valid_reg) begin
                acc_reg <= acc_reg + prod_ext;
            end
        end
    end

    // activation: drop fraction bits, saturate to DATA_W, then optional ReLU
    logic signed [ACC_W-1:0]  acc_shift;
    logic signed [DATA_W-1:0] act_sat;
    logic signed [DATA_W-1:0] act_value;
    assign acc_shift = acc_reg >>> FRAC_BITS;

    always_comb begin
        act_sat = acc_shift[DATA_W-1:0];
        if (acc_shift > SAT_MAX) begin
            act_sat = SAT_MAX[DATA_W-1:0];
        end else if (acc_shift < SAT_MIN) begin
            act_sat = SAT_MIN[DATA_W-1:0];
        end
        act_value = (relu_reg && act_sat[DATA_W-1]) ? '0 : act_sat;
    end

    // output decode from state
    logic                      done_c;
    logic [ADDR_W-1:0]         w_addr_c;
    logic [ADDR_W-1:0]         rd_addr_c;
    logic                      wr_en_c;
    logic [ADDR_W-1:0]         wr_addr_c;
    logic signed [DATA_W-1:0]  wr_data_c;

    // Addresses are driven only when they matter. The write strobe is masked by reset,
    // so a reset landing on a WRITE cycle does not disturb memory.
    always_comb begin
        busy_c    = (state_reg != S_IDLE) && (state_reg != S_FINISH);
        done_c    = (state_reg == S_FINISH);
        w_addr_c  = '0;
        rd_addr_c = '0;
        wr_en_c   = 1'b0;
        wr_addr_c = '0;
        wr_data_c = '0;
        if (state_reg == S_MAC) begin
            w_addr_c  = w_ptr_reg;
            rd_addr_c = rd_base_reg + i_reg;
        end
        if (state_reg == S_WRITE) begin
            wr_en_c   = !reset;
            wr_addr_c = wr_base_reg + j_reg;
            wr_data_c = act_value;
        end
    end

    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.err       = err_reg;
    assign bus.out_base  = out_base_reg;
    assign bus.w_addr    = w_addr_c;
    assign bus.n_rd_addr = rd_addr_c;
    assign bus.n_wr_en   = wr_en_c;
    assign bus.n_wr_addr = wr_addr_c;
    assign bus.n_wr_data = wr_data_c;

endmodule

// File: tb/tb_nn_layer_engine.sv
// Directed bench for nn_layer_engine.
// It uses behavioural weight and neuron memories with one-cycle read latency,
// and hand-computed expected values.
module tb_nn_layer_engine;
    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 8;
    localparam int MAX_LAYERS = 4;
    localparam int BUDGET     = 40;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    nn_layer_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_LAYERS(MAX_LAYERS)) bus ();

    nn_layer_engine #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(24), .FRAC_BITS(4), .MAX_LAYERS(MAX_LAYERS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] wmem [256];
    logic [7:0] nmem [256];

    // synchronous-read memories; neuron writes land on the clock edge
    always @(posedge clk) begin
        bus.w_data    <= wmem[bus.w_addr];
        bus.n_rd_data <= nmem[bus.n_rd_addr];
        if (bus.n_wr_en) nmem[bus.n_wr_addr] = bus.n_wr_data;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // per-run observation logs, indexed by cycle number after the start edge
    logic       busy_log [BUDGET+1];
    logic [7:0] wa_log   [BUDGET+1];
    logic [7:0] ra_log   [BUDGET+1];
    logic [7:0] wr_addr_q [8];
    logic [7:0] wr_data_q [8];
    int         wr_cyc_q  [8];
    int         nw;
    int         done_cyc;
    logic       done_err;
    logic [7:0] done_ob;

    task automatic set_desc(input int idx, input int nin, input int nout, input bit relu);
        @(negedge clk);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 2'(idx);
        bus.cfg_n_in  = 8'(nin);
        bus.cfg_n_out = 8'(nout);
        bus.cfg_relu  = relu;
        @(negedge clk);
        bus.cfg_we    = 1'b0;
    endtask

    // Start a run at edge 0, then observe cycles 1..BUDGET until done.
    // Optionally inject a busy-time start/cfg pulse or a reset at a given cycle.
    task automatic run_job(input string name, input int nl, input int base,
                           input int pulse_cyc, input int rst_cyc);
        nw = 0;
        done_cyc = -1;
        done_err = 1'b0;
        done_ob = 8'h00;
        for (int k = 0; k < 8; k++) begin
            wr_addr_q[k] = 8'h00;
            wr_data_q[k] = 8'h00;
            wr_cyc_q[k]  = -1;
        end
        @(negedge clk);
        bus.start      = 1'b1;
        bus.num_layers = 3'(nl);
        bus.in_base    = 8'(base);
        for (int c = 1; c <= BUDGET; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            busy_log[c] = bus.busy;
            wa_log[c]   = bus.w_addr;
            ra_log[c]   = bus.n_rd_addr;
            if (bus.n_wr_en) begin
                if (nw < 8) begin
                    wr_addr_q[nw] = bus.n_wr_addr;
                    wr_data_q[nw] = bus.n_wr_data;
                    wr_cyc_q[nw]  = c;
                end
                nw++;
            end
            if (c == pulse_cyc) begin
                bus.start      = 1'b1;
                bus.num_layers = 3'd2;
                bus.in_base    = 8'h80;
                bus.cfg_we     = 1'b1;
                bus.cfg_addr   = 2'd0;
                bus.cfg_n_in   = 8'd5;
                bus.cfg_n_out  = 8'd3;
            end
            if (c == pulse_cyc + 1) begin
                bus.start  = 1'b0;
                bus.cfg_we = 1'b0;
            end
            if (c == rst_cyc) reset = 1'b1;
            if (c == rst_cyc + 1) reset = 1'b0;
            if (bus.done) begin
                done_cyc = c;
                done_err = bus.err;
                done_ob  = bus.out_base;
                break;
            end
        end
        bus.start  = 1'b0;
        bus.cfg_we = 1'b0;
        $display("job %s: done_cycle=%0d writes=%0d out_base=0x%02h err=%0b",
                 name, done_cyc, nw, done_ob, done_err);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.num_layers = '0; bus.in_base = '0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_n_in = '0; bus.cfg_n_out = '0; bus.cfg_relu = 1'b0;
        for (int k = 0; k < 256; k++) begin
            wmem[k] = 8'h00;
            nmem[k] = 8'h00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_wr_en", 32'(bus.n_wr_en), 0);
        check("rst_out_base", 32'(bus.out_base), 0);
        check("rst_wr_data", 32'(bus.n_wr_data), 0);
        reset = 1'b0;

        // single layer: 1.0*1.0 + 2.0*1.0 = 3.0 -> 48
        set_desc(0, 2, 1, 0);
        wmem[0] = 8'd16; wmem[1] = 8'd32;
        nmem[8'h10] = 8'd16; nmem[8'h11] = 8'd16;
        run_job("single", 1, 8'h10, -10, -10);
        check("t1_done_cyc", done_cyc, 6);
        check("t1_nwrites", nw, 1);
        check("t1_wr_addr", wr_addr_q[0], 8'h12);
        check("t1_wr_data", wr_data_q[0], 8'd48);
        check("t1_wr_cyc", wr_cyc_q[0], 5);
        check("t1_out_base", done_ob, 8'h12);
        check("t1_busy_c1", 32'(busy_log[1]), 1);
        check("t1_busy_done", 32'(busy_log[6]), 0);
        check("t1_rd_c2", ra_log[2], 8'h10);
        check("t1_rd_c3", ra_log[3], 8'h11);
        check("t1_mem", nmem[8'h12], 8'd48);

        // positive saturation: 4*127*127>>4 = 4032 -> 127
        set_desc(0, 4, 1, 0);
        for (int k = 0; k < 4; k++) begin
            wmem[k] = 8'd127;
            nmem[8'h20 + k] = 8'd127;
            nmem[8'h30 + k] = 8'h81;
        end
        run_job("sat_pos", 1, 8'h20, -10, -10);
        check("sat_pos_done", done_cyc, 8);
        check("sat_pos_data", wr_data_q[0], 8'h7F);
        check("sat_pos_addr", wr_addr_q[0], 8'h24);
        // negative saturation: -64516>>>4 = -4033 -> -128
        run_job("sat_neg", 1, 8'h30, -10, -10);
        check("sat_neg_data", wr_data_q[0], 8'h80);
        // same layer with ReLU -> 0
        set_desc(0, 4, 1, 1);
        run_job("sat_relu", 1, 8'h30, -10, -10);
        check("relu_nwrites", nw, 1);
        check("relu_data", wr_data_q[0], 8'h00);
        check("relu_mem", nmem[8'h34], 8'h00);

        // two layers: 2->2 then 2->1 at in_base 0x40
        set_desc(0, 2, 2, 0);
        set_desc(1, 2, 1, 0);
        wmem[0] = 8'd16; wmem[1] = 8'd16; wmem[2] = 8'd8;
        wmem[3] = 8'd16; wmem[4] = 8'd16; wmem[5] = 8'hF0;
        nmem[8'h40] = 8'd16; nmem[8'h41] = 8'd32;
        run_job("two_layer", 2, 8'h40, -10, -10);
        check("tl_done_cyc", done_cyc, 15);
        check("tl_nwrites", nw, 3);
        check("tl_w0_addr", wr_addr_q[0], 8'h42);
        check("tl_w0_data", wr_data_q[0], 8'd48);
        check("tl_w1_addr", wr_addr_q[1], 8'h43);
        check("tl_w1_data", wr_data_q[1], 8'd40);
        check("tl_w1_cyc", wr_cyc_q[1], 9);
        check("tl_w2_addr", wr_addr_q[2], 8'h44);
        check("tl_w2_data", wr_data_q[2], 8'd8);
        check("tl_w2_cyc", wr_cyc_q[2], 14);
        check("tl_out_base", done_ob, 8'h44);
        check("tl_wa_c2", wa_log[2], 8'd0);
        check("tl_wa_c3", wa_log[3], 8'd1);
        check("tl_wa_c6", wa_log[6], 8'd2);
        check("tl_wa_c7", wa_log[7], 8'd3);
        check("tl_wa_c11", wa_log[11], 8'd4);
        check("tl_wa_c12", wa_log[12], 8'd5);
        check("tl_rd_c11", ra_log[11], 8'h42);
        check("tl_rd_c12", ra_log[12], 8'h43);

        // zero layers
        run_job("zero_layers", 0, 8'h55, -10, -10);
        check("z_done_cyc", done_cyc, 1);
        check("z_nwrites", nw, 0);
        check("z_out_base", done_ob, 8'h55);
        check("z_err", 32'(done_err), 0);

        // empty descriptor -> err
        set_desc(0, 0, 3, 0);
        run_job("bad_desc", 1, 8'h10, -10, -10);
        check("bad_done_cyc", done_cyc, 2);
        check("bad_err", 32'(done_err), 1);
        check("bad_nwrites", nw, 0);
        @(negedge clk);
        check("bad_err_held", 32'(bus.err), 1);

        // start and cfg_we pulsed while busy must not matter
        set_desc(0, 2, 1, 0);
        wmem[0] = 8'd16; wmem[1] = 8'd32;
        run_job("busy_pulse", 1, 8'h10, 2, -10);
        check("bp_done_cyc", done_cyc, 6);
        check("bp_nwrites", nw, 1);
        check("bp_wr_addr", wr_addr_q[0], 8'h12);
        check("bp_wr_data", wr_data_q[0], 8'd48);
        check("bp_err_clr", 32'(done_err), 0);
        run_job("desc_kept", 1, 8'h10, -10, -10);
        check("dk_done_cyc", done_cyc, 6);
        check("dk_nwrites", nw, 1);
        check("dk_wr_data", wr_data_q[0], 8'd48);

        // reset during MAC aborts the run
        run_job("reset_mid", 1, 8'h10, -10, 2);
        check("rm_busy_c3", 32'(busy_log[3]), 0);
        check("rm_nwrites", nw, 0);
        check("rm_no_done", done_cyc, -1);
        check("rm_out_base", 32'(bus.out_base), 0);

        // address wrap: reads 0xFE,0xFF,0x00, write 0x01
        set_desc(0, 3, 1, 0);
        wmem[0] = 8'd16; wmem[1] = 8'd16; wmem[2] = 8'd16;
        nmem[8'hFE] = 8'd16; nmem[8'hFF] = 8'd16; nmem[8'h00] = 8'd16;
        run_job("wrap", 1, 8'hFE, -10, -10);
        check("wr_done_cyc", done_cyc, 7);
        check("wr_rd_c2", ra_log[2], 8'hFE);
        check("wr_rd_c3", ra_log[3], 8'hFF);
        check("wr_rd_c4", ra_log[4], 8'h00);
        check("wr_wr_addr", wr_addr_q[0], 8'h01);
        check("wr_wr_data", wr_data_q[0], 8'd48);
        check("wr_out_base", done_ob, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
